// File: rtl/dds_cmd_pkg.sv
// Shared constants and types for the UART command-frame controller.
// Frame layout: header, target id, 11 payload bytes, tail.
package dds_cmd_pkg;

  localparam logic [7:0] FRAME_HDR     = 8'h55;
  localparam logic [7:0] FRAME_TAIL    = 8'hAA;
  localparam int         FRAME_LEN     = 14;
  localparam int         PAYLOAD_BYTES = 11;

  // Index of the final payload byte; the tail follows it.
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 2);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    TAIL,
    DELIVER
  } cmd_state_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_TIMEOUT,
    ERR_TAIL,
    ERR_TARGET,
    ERR_OVERRUN
  } err_code_t;

endpackage

// File: rtl/cmd_gap_timer.sv
// Inter-byte gap timer: counts cycles while enabled and flags the cycle in
// which the gap reaches TIMEOUT_CYC. A clear in that same cycle suppresses it.
module cmd_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 13020,
  parameter int unsigned TO_W        = 16
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] count_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count_reg <= '0;
    end else if (clear || !enable) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // count_reg is k cycles after the clearing strobe; fire on the TIMEOUT_CYC-th edge.
  assign expired = enable && !clear && (count_reg == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dds_cmd_ctrl.sv
// Assembles 14-byte UART command frames, validates them, and hands each good
// frame (target id + 88-bit payload) to the configuration side over valid/ready.
module dds_cmd_ctrl
  import dds_cmd_pkg::*;
#(
  parameter int unsigned NUM_TARGETS = 2,
  parameter int unsigned TIMEOUT_CYC = 13020,
  parameter int unsigned TO_W        = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic [7:0]  cfg_target,
  output logic [87:0] cfg_payload,
  output logic        busy,
  output logic        err_pulse,
  output logic [2:0]  err_code,
  output logic [15:0] frame_cnt
);

  cmd_state_t                       state_reg;
  logic [3:0]                       idx_reg;
  logic [7:0]                       target_shadow_reg;
  logic [PAYLOAD_BYTES*8-1:0]       payload_shadow_reg;
  logic [PAYLOAD_BYTES-1:0]         byte_we;
  logic                             cfg_valid_reg;
  logic [7:0]                       cfg_target_reg;
  logic [87:0]                      cfg_payload_reg;
  logic                             err_pulse_reg;
  err_code_t                        err_code_reg;
  logic [15:0]                      frame_cnt_reg;
  logic                             timer_en;
  logic                             timer_expired;
  logic                             target_ok;

  assign timer_en  = (state_reg == RECV) || (state_reg == TAIL);
  assign target_ok = (target_shadow_reg != 8'd0) && (target_shadow_reg <= 8'(NUM_TARGETS));

  cmd_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_gap_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (rx_valid),
    .enable    (timer_en),
    .expired   (timer_expired)
  );

  // Frame byte gi+2 lands in payload byte lane gi.
  generate
    for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_byte_we
      assign byte_we[gi] = rx_valid && (state_reg == RECV) && (idx_reg == 4'(gi + 2));
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      payload_shadow_reg <= '0;
    end else begin
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
        if (byte_we[i]) payload_shadow_reg[i*8 +: 8] <= rx_data;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg         <= IDLE;
      idx_reg           <= 4'd0;
      target_shadow_reg <= 8'd0;
      cfg_valid_reg     <= 1'b0;
      cfg_target_reg    <= 8'd0;
      cfg_payload_reg   <= '0;
      err_pulse_reg     <= 1'b0;
      err_code_reg      <= ERR_NONE;
      frame_cnt_reg     <= 16'd0;
    end else begin
      err_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rx_valid && (rx_data == FRAME_HDR)) begin
            state_reg <= RECV;
            idx_reg   <= 4'd1;
          end
        end
        RECV: begin
          // A byte arriving in the expiry cycle keeps the frame alive.
          if (rx_valid) begin
            if (idx_reg == 4'd1) target_shadow_reg <= rx_data;
            if (idx_reg == LAST_IDX) begin
              state_reg <= TAIL;
            end else begin
              idx_reg <= idx_reg + 4'd1;
            end
          end else if (timer_expired) begin
            err_pulse_reg <= 1'b1;
            err_code_reg  <= ERR_TIMEOUT;
            state_reg     <= IDLE;
          end
        end
        TAIL: begin
          if (rx_valid) begin
            if (rx_data != FRAME_TAIL) begin
              err_pulse_reg <= 1'b1;
              err_code_reg  <= ERR_TAIL;
              state_reg     <= IDLE;
            end else if (!target_ok) begin
              err_pulse_reg <= 1'b1;
              err_code_reg  <= ERR_TARGET;
              state_reg     <= IDLE;
            end else begin
              cfg_valid_reg   <= 1'b1;
              cfg_target_reg  <= target_shadow_reg;
              cfg_payload_reg <= payload_shadow_reg;
              state_reg       <= DELIVER;
            end
          end else if (timer_expired) begin
            err_pulse_reg <= 1'b1;
            err_code_reg  <= ERR_TIMEOUT;
            state_reg     <= IDLE;
          end
        end
        DELIVER: begin
          if (rx_valid) begin
            err_pulse_reg <= 1'b1;
            err_code_reg  <= ERR_OVERRUN;
          end
          if (cfg_ready) begin
            cfg_valid_reg <= 1'b0;
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cfg_valid   = cfg_valid_reg;
  assign cfg_target  = cfg_target_reg;
  assign cfg_payload = cfg_payload_reg;
  assign busy        = (state_reg != IDLE);
  assign err_pulse   = err_pulse_reg;
  assign err_code    = err_code_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_dds_cmd_ctrl.sv
// Directed bench for dds_cmd_ctrl: good frames, bad tail/target, gap timeout,
// overrun under back-pressure and mid-frame reset.
module tb_dds_cmd_ctrl;

  localparam int TIMEOUT_CYC = 13020;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        cfg_valid;
  logic        cfg_ready = 1'b1;
  logic [7:0]  cfg_target;
  logic [87:0] cfg_payload;
  logic        busy;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int err_pulse_cnt = 0;
  int valid_rise_cnt = 0;
  logic valid_prev = 1'b0;
  logic [15:0] exp_fc = 16'd0;

  localparam logic [87:0] PL1 = 88'h0CFF_0000_0000_4400_0301_01;
  localparam logic [87:0] PL2 = 88'h1122_3344_5566_7788_99AA_BB;
  localparam logic [87:0] PL3 = 88'hA5A5_5555_0102_0304_0506_07;

  dds_cmd_ctrl #(
    .NUM_TARGETS (2),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (16)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_target  (cfg_target),
    .cfg_payload (cfg_payload),
    .busy        (busy),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .frame_cnt   (frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Event monitor on the opposite edge: counts error strobes and cfg_valid rises.
  always @(negedge sys_clk) begin
    if (err_pulse) err_pulse_cnt++;
    if (cfg_valid && !valid_prev) valid_rise_cnt++;
    valid_prev = cfg_valid;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Sends a frame; returns one tick after the tail strobe edge, with a spacer
  // cycle between bytes except after the tail.
  task automatic send_frame(input logic [7:0] tgt, input logic [87:0] pl, input logic [7:0] tail);
    send_byte(8'h55);
    tick();
    send_byte(tgt);
    tick();
    for (int i = 0; i < 11; i++) begin
      send_byte(pl[i*8 +: 8]);
      tick();
    end
    send_byte(tail);
  endtask

  task automatic check_accept(input string name, input logic [7:0] tgt, input logic [87:0] pl);
    if (cfg_valid !== 1'b1) begin
      $display("FAIL %s_valid: got %b expected 1", name, cfg_valid); errors++;
    end
    checks++;
    if (cfg_target !== tgt) begin
      $display("FAIL %s_target: got %h expected %h", name, cfg_target, tgt); errors++;
    end
    checks++;
    if (cfg_payload !== pl) begin
      $display("FAIL %s_payload: got %h expected %h", name, cfg_payload, pl); errors++;
    end
    checks++;
    tick();
    exp_fc = exp_fc + 16'd1;
    if (cfg_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== exp_fc) begin
      $display("FAIL %s_done: valid=%b busy=%b frame_cnt=%0d expected 0/0/%0d",
               name, cfg_valid, busy, frame_cnt, exp_fc); errors++;
    end
    checks++;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) tick();
    if ({cfg_valid, cfg_target, cfg_payload, busy, err_pulse, err_code, frame_cnt} !== '0) begin
      $display("FAIL reset_outputs: valid=%b tgt=%h pl=%h busy=%b ep=%b ec=%0d fc=%0d expected all 0",
               cfg_valid, cfg_target, cfg_payload, busy, err_pulse, err_code, frame_cnt); errors++;
    end
    checks++;
    sys_rst_n = 1'b1;
    tick();
    send_byte(8'h12);
    tick();
    if (busy !== 1'b0 || err_pulse_cnt != 0) begin
      $display("FAIL idle_drop: busy=%b err_pulses=%0d expected 0/0", busy, err_pulse_cnt); errors++;
    end
    checks++;
    $display("test_reset done");
  endtask

  task automatic test_good_frame();
    int ep0 = err_pulse_cnt;
    int vr0 = valid_rise_cnt;
    cfg_ready = 1'b1;
    send_frame(8'h01, PL1, 8'hAA);
    check_accept("good", 8'h01, PL1);
    if (err_pulse_cnt != ep0 || valid_rise_cnt != vr0 + 1) begin
      $display("FAIL good_events: err_pulses=%0d valid_rises=%0d expected %0d/%0d",
               err_pulse_cnt - ep0, valid_rise_cnt - vr0, 0, 1); errors++;
    end
    checks++;
    $display("test_good_frame done");
  endtask

  task automatic test_bad_tail();
    int ep0 = err_pulse_cnt;
    int vr0 = valid_rise_cnt;
    send_frame(8'h01, PL1, 8'hAB);
    repeat (3) tick();
    if (err_pulse_cnt != ep0 + 1 || err_code !== 3'd2 || busy !== 1'b0 || valid_rise_cnt != vr0) begin
      $display("FAIL bad_tail: pulses=%0d code=%0d busy=%b valid_rises=%0d expected 1/2/0/0",
               err_pulse_cnt - ep0, err_code, busy, valid_rise_cnt - vr0); errors++;
    end
    checks++;
    $display("test_bad_tail done");
  endtask

  task automatic test_bad_target();
    int ep0 = err_pulse_cnt;
    int vr0 = valid_rise_cnt;
    send_frame(8'h05, PL2, 8'hAA);
    repeat (2) tick();
    if (err_pulse_cnt != ep0 + 1 || err_code !== 3'd3 || valid_rise_cnt != vr0 || busy !== 1'b0) begin
      $display("FAIL bad_target: pulses=%0d code=%0d valid_rises=%0d busy=%b expected 1/3/0/0",
               err_pulse_cnt - ep0, err_code, valid_rise_cnt - vr0, busy); errors++;
    end
    checks++;
    // Target 0 is also out of range.
    send_frame(8'h00, PL2, 8'hAA);
    repeat (2) tick();
    if (err_pulse_cnt != ep0 + 2 || err_code !== 3'd3 || valid_rise_cnt != vr0) begin
      $display("FAIL target_zero: pulses=%0d code=%0d valid_rises=%0d expected 2/3/0",
               err_pulse_cnt - ep0, err_code, valid_rise_cnt - vr0); errors++;
    end
    checks++;
    send_frame(8'h02, PL2, 8'hAA);
    check_accept("target2", 8'h02, PL2);
    $display("test_bad_target done");
  endtask

  task automatic test_timeout();
    int ep0 = err_pulse_cnt;
    int seen_at = -1;
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    for (int k = 1; k <= TIMEOUT_CYC + 10; k++) begin
      if (err_pulse && seen_at < 0) seen_at = k - 1;
      tick();
    end
    if (seen_at != TIMEOUT_CYC) begin
      $display("FAIL timeout_latency: pulse %0d cycles after last strobe expected %0d", seen_at, TIMEOUT_CYC);
      errors++;
    end
    checks++;
    if (err_code !== 3'd1 || err_pulse_cnt != ep0 + 1 || busy !== 1'b0) begin
      $display("FAIL timeout_state: code=%0d pulses=%0d busy=%b expected 1/1/0",
               err_code, err_pulse_cnt - ep0, busy); errors++;
    end
    checks++;
    send_frame(8'h01, PL3, 8'hAA);
    check_accept("after_timeout", 8'h01, PL3);
    $display("test_timeout done");
  endtask

  task automatic test_back_to_back();
    int ep0 = err_pulse_cnt;
    int unstable = 0;
    cfg_ready = 1'b0;
    send_frame(8'h02, PL1, 8'hAA);
    for (int k = 0; k < 5000; k++) begin
      if (k == 100) begin
        rx_data  = 8'h55;
        rx_valid = 1'b1;
      end else begin
        rx_valid = 1'b0;
      end
      if (cfg_valid !== 1'b1 || cfg_target !== 8'h02 || cfg_payload !== PL1) unstable++;
      tick();
    end
    rx_valid = 1'b0;
    if (unstable != 0) begin
      $display("FAIL hold_stable: %0d unstable cycles expected 0", unstable); errors++;
    end
    checks++;
    if (err_code !== 3'd4 || err_pulse_cnt != ep0 + 1 || frame_cnt !== exp_fc) begin
      $display("FAIL overrun: code=%0d pulses=%0d frame_cnt=%0d expected 4/1/%0d",
               err_code, err_pulse_cnt - ep0, frame_cnt, exp_fc); errors++;
    end
    checks++;
    cfg_ready = 1'b1;
    check_accept("held_frame", 8'h02, PL1);
    $display("test_back_to_back done");
  endtask

  task automatic test_mid_reset();
    int ep0 = err_pulse_cnt;
    int vr0 = valid_rise_cnt;
    send_byte(8'h55);
    send_byte(8'h02);
    for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i));
    sys_rst_n = 1'b0;
    #1;
    if ({cfg_valid, cfg_target, cfg_payload, busy, err_pulse, err_code, frame_cnt} !== '0) begin
      $display("FAIL mid_reset_outputs: valid=%b busy=%b ep=%b ec=%0d fc=%0d expected all 0",
               cfg_valid, busy, err_pulse, err_code, frame_cnt); errors++;
    end
    checks++;
    exp_fc = 16'd0;
    tick();
    sys_rst_n = 1'b1;
    tick();
    if (err_pulse_cnt != ep0 || valid_rise_cnt != vr0) begin
      $display("FAIL mid_reset_silent: pulses=%0d valid_rises=%0d expected 0/0",
               err_pulse_cnt - ep0, valid_rise_cnt - vr0); errors++;
    end
    checks++;
    send_frame(8'h01, PL2, 8'hAA);
    check_accept("after_reset", 8'h01, PL2);
    $display("test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_tail();
    test_bad_target();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
